// File: rtl/buzzer_note_sequencer.sv
// Melody sequencer for the buzzer: walks a note ROM, times each note in beats,
// inserts a silent gap between notes and lets a one-shot sound effect preempt
// the music. After an effect the interrupted ROM entry replays from its start.
module buzzer_note_sequencer #(
  parameter int BEAT_CYCLES = 6250000,
  parameter int GAP_CYCLES  = 250000,
  parameter int ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play_en,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  input  logic              sfx_req,
  input  logic [7:0]        sfx_tune,
  input  logic [7:0]        sfx_beats,
  output logic              sfx_ack,
  output logic [7:0]        tune,
  output logic              busy,
  output logic              song_done
);

  // One cycle counter serves beats (NOTE/SFX) and the inter-note gap.
  localparam int MAX_CYC = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0]     BEAT_LAST = CW'(BEAT_CYCLES - 1);
  localparam logic [CW-1:0]     GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0]     CYC_ZERO  = CW'(0);
  localparam logic [CW-1:0]     CYC_ONE   = CW'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_NOTE  = 3'd3,
    ST_GAP   = 3'd4,
    ST_SFX   = 3'd5
  } state_t;

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [7:0]          tune_r, tune_s;
  logic [7:0]          beat_r, beat_s;
  logic [CW-1:0]       cyc_r, cyc_s;
  logic                ack_r, ack_s;
  logic                done_r, done_s;
  logic                busy_r;
  logic                music_s;

  assign rom_addr  = addr_r;
  assign tune      = tune_r;
  assign sfx_ack   = ack_r;
  assign song_done = done_r;
  assign busy      = busy_r;

  // States in which dropping play_en pauses the music.
  assign music_s = (state_r == ST_FETCH) || (state_r == ST_LOAD) ||
                   (state_r == ST_NOTE)  || (state_r == ST_GAP);

  // Next-state and next-output logic; sound effect beats pause beats normal flow.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    tune_s  = tune_r;
    beat_s  = beat_r;
    cyc_s   = cyc_r;
    ack_s   = 1'b0;
    done_s  = 1'b0;
    if (sfx_req && (state_r != ST_SFX)) begin
      ack_s   = 1'b1;
      tune_s  = sfx_tune;
      beat_s  = (sfx_beats == 8'd0) ? 8'd1 : sfx_beats;
      cyc_s   = CYC_ZERO;
      state_s = ST_SFX;
    end else if (!play_en && music_s) begin
      // Pause: the ROM address is kept so the same note restarts on resume.
      state_s = ST_IDLE;
      tune_s  = 8'd0;
      beat_s  = 8'd0;
      cyc_s   = CYC_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tune_s = 8'd0;
          beat_s = 8'd0;
          cyc_s  = CYC_ZERO;
          if (play_en) begin
            state_s = ST_FETCH;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_FETCH: begin
          // ROM answers one cycle after the address is presented.
          state_s = ST_LOAD;
        end
        ST_LOAD: begin
          if (rom_data[7:0] == 8'd0) begin
            done_s = 1'b1;
            addr_s = ADDR_ZERO;
            if (loop_en && play_en) begin
              state_s = ST_FETCH;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            tune_s  = rom_data[15:8];
            beat_s  = rom_data[7:0];
            cyc_s   = CYC_ZERO;
            state_s = ST_NOTE;
          end
        end
        ST_NOTE, ST_SFX: begin
          if (cyc_r == BEAT_LAST) begin
            cyc_s = CYC_ZERO;
            if (beat_r <= 8'd1) begin
              tune_s = 8'd0;
              beat_s = 8'd0;
              if (state_r == ST_NOTE) begin
                state_s = ST_GAP;
              end else if (play_en) begin
                state_s = ST_FETCH;
              end else begin
                state_s = ST_IDLE;
              end
            end else begin
              beat_s = beat_r - 8'd1;
            end
          end else begin
            cyc_s = cyc_r + CYC_ONE;
          end
        end
        ST_GAP: begin
          if (cyc_r == GAP_LAST) begin
            cyc_s   = CYC_ZERO;
            addr_s  = addr_r + ADDR_ONE;
            state_s = ST_FETCH;
          end else begin
            cyc_s = cyc_r + CYC_ONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          tune_s  = 8'd0;
          beat_s  = 8'd0;
          cyc_s   = CYC_ZERO;
        end
      endcase
    end
  end

  // State and datapath registers; every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      addr_r  <= ADDR_ZERO;
      tune_r  <= 8'd0;
      beat_r  <= 8'd0;
      cyc_r   <= CYC_ZERO;
      ack_r   <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      tune_r  <= tune_s;
      beat_r  <= beat_s;
      cyc_r   <= cyc_s;
      ack_r   <= ack_s;
      done_r  <= done_s;
      busy_r  <= (state_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_buzzer_note_sequencer.sv
// Bench for buzzer_note_sequencer: directed scenarios plus randomized play,
// every cycle compared against a timeline model of the expected outputs.
module tb_buzzer_note_sequencer;

  localparam int BEAT = 4;
  localparam int GAP  = 2;
  localparam int AW   = 3;

  localparam logic [1:0] K_IDLE  = 2'd0;
  localparam logic [1:0] K_MUSIC = 2'd1;
  localparam logic [1:0] K_SFX   = 2'd2;
  localparam logic [1:0] T_NONE   = 2'd0;
  localparam logic [1:0] T_WAIT   = 2'd1;
  localparam logic [1:0] T_GAPEND = 2'd2;
  localparam logic [1:0] T_MARKER = 2'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          play_en = 1'b0;
  logic          loop_en = 1'b0;
  logic          sfx_req = 1'b0;
  logic [7:0]    sfx_tune = 8'd0;
  logic [7:0]    sfx_beats = 8'd0;
  logic [15:0]   rom_data;
  logic [AW-1:0] rom_addr;
  logic          sfx_ack;
  logic [7:0]    tune;
  logic          busy;
  logic          song_done;

  logic [15:0]   rom [8];
  int            n_cmp = 0;
  int            n_bad = 0;

  // One slot = what the outputs must show during one clock cycle.
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] tune;
    logic [2:0] addr;
    logic       ack;
    logic       done;
    logic [1:0] tag;
  } slot_t;

  slot_t cur;
  slot_t fut[$];

  buzzer_note_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .play_en(play_en), .loop_en(loop_en),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .sfx_req(sfx_req), .sfx_tune(sfx_tune), .sfx_beats(sfx_beats),
    .sfx_ack(sfx_ack), .tune(tune), .busy(busy), .song_done(song_done)
  );

  always #5 clk = ~clk;

  // Synchronous note ROM: data one cycle after the address.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic slot_t mk(input logic [1:0] k, input logic [7:0] t,
                               input logic [2:0] a, input logic [1:0] tg);
    slot_t s;
    s.kind = k; s.tune = t; s.addr = a; s.ack = 1'b0; s.done = 1'b0; s.tag = tg;
    return s;
  endfunction

  // Whole life of one ROM entry: fetch, load, sounding beats, silent gap.
  task automatic push_note(input logic [2:0] a);
    int d;
    d = int'(rom[a][7:0]);
    fut.push_back(mk(K_MUSIC, 8'd0, a, T_NONE));
    if (d == 0) begin
      fut.push_back(mk(K_MUSIC, 8'd0, a, T_MARKER));
    end else begin
      fut.push_back(mk(K_MUSIC, 8'd0, a, T_NONE));
      for (int i = 0; i < d * BEAT; i++) fut.push_back(mk(K_MUSIC, rom[a][15:8], a, T_NONE));
      for (int i = 0; i < GAP; i++) fut.push_back(mk(K_MUSIC, 8'd0, a, (i == GAP - 1) ? T_GAPEND : T_NONE));
    end
  endtask

  // Advance the timeline by one cycle given the inputs now being applied.
  task automatic model_advance();
    slot_t s;
    int nb;
    if (sfx_req && cur.kind != K_SFX) begin
      fut.delete();
      nb = (sfx_beats == 8'd0) ? 1 : int'(sfx_beats);
      for (int i = 0; i < nb * BEAT; i++) begin
        s = mk(K_SFX, sfx_tune, cur.addr, (i == nb * BEAT - 1) ? T_WAIT : T_NONE);
        s.ack = (i == 0);
        fut.push_back(s);
      end
    end else if (!play_en && cur.kind == K_MUSIC) begin
      fut.delete();
      fut.push_back(mk(K_IDLE, 8'd0, cur.addr, T_WAIT));
    end else if (fut.size() == 0) begin
      if (cur.tag == T_GAPEND) begin
        push_note(cur.addr + 3'd1);
      end else if (cur.tag == T_MARKER) begin
        if (loop_en) push_note(3'd0);
        else fut.push_back(mk(K_IDLE, 8'd0, 3'd0, T_WAIT));
        s = fut.pop_front();
        s.done = 1'b1;
        fut.push_front(s);
      end else if (play_en) begin
        push_note(cur.addr);
      end else begin
        fut.push_back(mk(K_IDLE, 8'd0, cur.addr, T_WAIT));
      end
    end
    cur = fut.pop_front();
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic step();
    model_advance();
    @(posedge clk);
    @(negedge clk);
    check_eq("tune", 32'(tune), 32'(cur.tune));
    check_eq("rom_addr", 32'(rom_addr), 32'(cur.addr));
    check_eq("busy", 32'(busy), 32'(cur.kind != K_IDLE));
    check_eq("sfx_ack", 32'(sfx_ack), 32'(cur.ack));
    check_eq("song_done", 32'(song_done), 32'(cur.done));
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_tune", 32'(tune), 32'd0);
    check_eq("rst_addr", 32'(rom_addr), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ack", 32'(sfx_ack), 32'd0);
    check_eq("rst_done", 32'(song_done), 32'd0);
    fut.delete();
    cur = mk(K_IDLE, 8'd0, 3'd0, T_WAIT);
    sfx_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_rom(input logic [15:0] w0, input logic [15:0] w1);
    for (int i = 0; i < 8; i++) rom[i] = 16'h0000;
    rom[0] = w0;
    rom[1] = w1;
  endtask

  initial begin
    int c21, c25, c55, c33, cack, cdone, cdone2, wraps, hit;
    logic [2:0] prev_addr;

    load_rom(16'h2103, 16'h2502);
    @(negedge clk);
    apply_reset();

    // Reset asserted in the middle of note 0x21.
    play_en = 1'b1;
    c21 = 0;
    for (int i = 0; i < 40 && c21 < 3; i++) begin
      step();
      if (tune == 8'h21) c21++;
    end
    check_eq("pre_rst_tune", 32'(tune), 32'h21);
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    play_en = 1'b0;
    apply_reset();
    for (int i = 0; i < 6; i++) step();

    // Basic song, no looping.
    play_en = 1'b1;
    loop_en = 1'b0;
    c21 = 0; c25 = 0; cdone = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (tune == 8'h21) c21++;
      if (tune == 8'h25) c25++;
      if (song_done) begin
        cdone++;
        check_eq("end_addr", 32'(rom_addr), 32'd0);
        check_eq("end_busy", 32'(busy), 32'd0);
        break;
      end
    end
    check_eq("basic_c21", 32'(c21), 32'd12);
    check_eq("basic_c25", 32'(c25), 32'd8);
    check_eq("basic_done", 32'(cdone), 32'd1);
    play_en = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Looping song.
    apply_reset();
    play_en = 1'b1;
    loop_en = 1'b1;
    for (int i = 0; i < 70; i++) step();

    // Sound effect preempting the 5th cycle of note 0x21.
    apply_reset();
    loop_en = 1'b0;
    play_en = 1'b1;
    c21 = 0;
    for (int i = 0; i < 40 && c21 < 5; i++) begin
      step();
      if (tune == 8'h21) c21++;
    end
    sfx_req = 1'b1; sfx_tune = 8'h55; sfx_beats = 8'd2;
    step();
    sfx_req = 1'b0;
    c55 = (tune == 8'h55) ? 1 : 0;
    cack = sfx_ack ? 1 : 0;
    c21 = 0;
    for (int i = 0; i < 29; i++) begin
      step();
      if (tune == 8'h55) c55++;
      if (tune == 8'h21) c21++;
      if (sfx_ack) cack++;
    end
    check_eq("sfx_c55", 32'(c55), 32'd8);
    check_eq("sfx_acks", 32'(cack), 32'd1);
    check_eq("sfx_replay_c21", 32'(c21), 32'd12);

    // Pause during the gap after note 0, then resume.
    apply_reset();
    play_en = 1'b1;
    c21 = 0;
    for (int i = 0; i < 40 && c21 < 12; i++) begin
      step();
      if (tune == 8'h21) c21++;
    end
    step();
    play_en = 1'b0;
    step();
    check_eq("pause_busy", 32'(busy), 32'd0);
    check_eq("pause_addr", 32'(rom_addr), 32'd0);
    step(); step();
    play_en = 1'b1;
    c21 = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tune == 8'h21) c21++;
    end
    check_eq("resume_c21", 32'(c21), 32'd12);

    // Sound effect requested while the end marker is being loaded.
    load_rom(16'h2101, 16'h0000);
    apply_reset();
    play_en = 1'b1;
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      if (cur.tag == T_MARKER) begin
        hit = 1;
        break;
      end
      step();
    end
    check_eq("marker_seen", 32'(hit), 32'd1);
    sfx_req = 1'b1; sfx_tune = 8'h33; sfx_beats = 8'd0;
    step();
    sfx_req = 1'b0;
    c33 = (tune == 8'h33) ? 1 : 0;
    cdone = song_done ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (tune == 8'h33) c33++;
      if (song_done) cdone++;
    end
    cdone2 = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (song_done) cdone2++;
    end
    check_eq("marker_sfx_c33", 32'(c33), 32'd4);
    check_eq("marker_sfx_no_done", 32'(cdone), 32'd0);
    check_eq("marker_reread_done", 32'(cdone2), 32'd1);

    // Randomized play; run 0 has no end marker so the address must wrap.
    for (int run = 0; run < 3; run++) begin
      for (int i = 0; i < 8; i++) begin
        logic [7:0] d;
        if (run != 0 && $urandom_range(0, 5) == 0) d = 8'd0;
        else d = 8'($urandom_range(1, 3));
        rom[i] = {8'($urandom_range(1, 255)), d};
      end
      apply_reset();
      play_en = 1'b1;
      loop_en = 1'($urandom_range(0, 1));
      wraps = 0; cdone = 0;
      prev_addr = 3'd0;
      for (int cyc = 0; cyc < ((run == 0) ? 3000 : 1500); cyc++) begin
        if ($urandom_range(0, 59) == 0) play_en = ~play_en;
        if ($urandom_range(0, 199) == 0) loop_en = ~loop_en;
        sfx_req = (sfx_req && $urandom_range(0, 1) == 0) || ($urandom_range(0, 29) == 0);
        sfx_tune = 8'($urandom_range(1, 255));
        sfx_beats = 8'($urandom_range(0, 3));
        step();
        if (prev_addr == 3'd7 && rom_addr == 3'd0) wraps++;
        if (song_done) cdone++;
        prev_addr = rom_addr;
      end
      if (run == 0) begin
        check_eq("wrap_seen", 32'(wraps > 0), 32'd1);
        check_eq("wrap_no_done", 32'(cdone), 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
